// File: rtl/btn_pkg.sv
// Shared types and constants for the button event arbiter.
// No logic of its own; holds the FSM encoding, counter widths and reset constants.
// No backpressure: package only.
package btn_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    localparam int MAX_BTN    = 16;
    localparam int DROP_CNT_W = 8;
    // Wide enough for the number of simultaneous drops with MAX_BTN buttons.
    localparam int DROP_INC_W = 5;

    // Buttons already held when reset releases must not look like fresh presses.
    localparam logic [MAX_BTN-1:0] PREV_RST_VAL = '1;

    function automatic logic [DROP_CNT_W-1:0] sat_add_drop(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [DROP_INC_W-1:0] inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cnt} + {{(DROP_CNT_W - DROP_INC_W + 1){1'b0}}, inc};
        return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/btn_event_arbiter_rr_pick.sv
// Round-robin picker: first set req bit searching upward from last+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the grant.
module rr_pick #(
    parameter  int N_BTN = 4,
    localparam int IDX_W = $clog2(N_BTN)
) (
    input  logic [N_BTN-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk from the farthest candidate to the nearest so the nearest request overwrites.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = N_BTN; off >= 1; off--) begin
            cand     = (int'(last) + off) % N_BTN;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                grant_idx = cand_idx;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Latches debounced button rising edges and serves them round-robin as one event stream.
// Latency: 2 edges from first sampled high level to evt_valid; at most one event per 2 clocks.
// Backpressure: evt_valid/evt_idx held until evt_ready; presses on an already pending button are counted in drop_cnt. Auto-repeat under BTN_REPEAT_EN.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter  int N_BTN         = 4,
    parameter  int REPEAT_CYCLES = 25_000_000,
    localparam int IDX_W         = $clog2(N_BTN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_BTN-1:0]      btn_level,
    input  logic                  enable,
    output logic                  evt_valid,
    output logic [IDX_W-1:0]      evt_idx,
    input  logic                  evt_ready,
    output logic [N_BTN-1:0]      pending,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [N_BTN-1:0] PREV_INIT = PREV_RST_VAL[N_BTN-1:0];

    logic [N_BTN-1:0]      prev;
    logic [N_BTN-1:0]      rise;
    logic [N_BTN-1:0]      rep_rise;
    logic [N_BTN-1:0]      set_vec;
    logic [N_BTN-1:0]      clr_vec;
    logic [N_BTN-1:0]      drop_vec;
    logic [DROP_INC_W-1:0] drop_n;
    logic [IDX_W-1:0]      last;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    arb_state_t            state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= PREV_INIT;
        end else begin
            prev <= btn_level;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int CNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] hold_cnt [N_BTN];

    always_comb begin
        rep_rise = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rep_rise[i] = btn_level[i] & enable & (hold_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_level[i] || !enable) begin
                    hold_cnt[i] <= '0;
                end else if (hold_cnt[i] == CNT_LAST) begin
                    hold_cnt[i] <= '0;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_repeat_cfg;

    assign rep_rise          = '0;
    assign unused_repeat_cfg = (REPEAT_CYCLES != 0);
`endif

    assign rise    = (btn_level & ~prev) | rep_rise;
    assign set_vec = enable ? rise : '0;

    rr_pick #(
        .N_BTN (N_BTN)
    ) u_pick (
        .req       (pending),
        .last      (last),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    always_comb begin
        clr_vec = '0;
        if (state == ST_IDLE && grant_any) begin
            clr_vec[grant_idx] = 1'b1;
        end
    end

    // A bit being granted this cycle can accept a new press without counting a drop.
    assign drop_vec = set_vec & pending & ~clr_vec;

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < N_BTN; i++) begin
            drop_n = drop_n + DROP_INC_W'(drop_vec[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            drop_cnt <= '0;
        end else begin
            pending  <= (pending & ~clr_vec) | set_vec;
            drop_cnt <= sat_add_drop(drop_cnt, drop_n);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            last      <= IDX_W'(N_BTN - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        evt_idx   <= grant_idx;
                        evt_valid <= 1'b1;
                        last      <= grant_idx;
                        state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter: expected event indices queued by stimulus,
// popped and compared by a monitor on every handshake.
module tb_btn_event_arbiter;

    localparam int N_BTN = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] btn_level = 4'b0010;
    logic             enable = 1'b1;
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_ready = 1'b0;
    logic [N_BTN-1:0] pending;
    logic [7:0]       drop_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .N_BTN         (N_BTN),
        .REPEAT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .enable    (enable),
        .evt_valid (evt_valid),
        .evt_idx   (evt_idx),
        .evt_ready (evt_ready),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_evt(input int unsigned idx);
        exp_q.push_back(idx);
    endtask

    // Monitor: a handshake seen on the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got idx %0d, expected no event", evt_idx);
            end else begin
                check("event_idx", 32'(evt_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset with btn1 held: no event afterwards.
        tick(2);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_idx", 32'(evt_idx), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        evt_ready = 1'b1;
        tick(6);
        check("held_no_pending", 32'(pending), 32'd0);
        check("held_no_valid", 32'(evt_valid), 32'd0);

        // Release and press btn1: pending after edge k, event after k+1.
        btn_level = 4'b0000;
        tick(1);
        expect_evt(1);
        btn_level = 4'b0010;
        tick(1);
        check("lat_pending_k", 32'(pending), 32'b0010);
        check("lat_valid_k", 32'(evt_valid), 32'd0);
        tick(1);
        check("lat_valid_k1", 32'(evt_valid), 32'd1);
        check("lat_idx_k1", 32'(evt_idx), 32'd1);
        check("lat_pending_k1", 32'(pending), 32'd0);
        btn_level = 4'b0000;
        tick(3);

        // Fresh reset so last = 3; btn0 + btn2 together serve 0 then 2.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        expect_evt(0);
        expect_evt(2);
        btn_level = 4'b0101;
        tick(1);
        check("pair_pending", 32'(pending), 32'b0101);
        tick(1);
        check("pair_first_valid", 32'(evt_valid), 32'd1);
        check("pair_first_idx", 32'(evt_idx), 32'd0);
        check("pair_first_pending", 32'(pending), 32'b0100);
        tick(1);
        check("pair_bubble", 32'(evt_valid), 32'd0);
        tick(1);
        check("pair_second_valid", 32'(evt_valid), 32'd1);
        check("pair_second_idx", 32'(evt_idx), 32'd2);
        btn_level = 4'b0000;
        tick(3);
        // last = 2 now; search wraps through 3 to 0 first.
        expect_evt(0);
        expect_evt(2);
        btn_level = 4'b0101;
        tick(6);
        btn_level = 4'b0000;
        tick(3);

        // Stall in OFFER for 10 cycles; btn3 pressed twice meanwhile.
        evt_ready = 1'b0;
        expect_evt(1);
        btn_level = 4'b0010;
        tick(2);
        check("stall_start_valid", 32'(evt_valid), 32'd1);
        for (int j = 0; j < 10; j++) begin
            case (j)
                1: begin btn_level = 4'b1000; expect_evt(3); end
                3: btn_level = 4'b1000;
                default: btn_level = 4'b0000;
            endcase
            tick(1);
            check("stall_valid", 32'(evt_valid), 32'd1);
            check("stall_idx", 32'(evt_idx), 32'd1);
        end
        check("stall_pending", 32'(pending), 32'b1000);
        check("stall_drop_cnt", 32'(drop_cnt), 32'd1);
        evt_ready = 1'b1;
        tick(1);
        check("stall_release_valid", 32'(evt_valid), 32'd0);
        tick(1);
        check("stall_next_valid", 32'(evt_valid), 32'd1);
        check("stall_next_idx", 32'(evt_idx), 32'd3);
        tick(3);

        // Disable: btn1 ignored, btn0 pending from before still delivered.
        evt_ready = 1'b0;
        expect_evt(2);
        btn_level = 4'b0100;
        tick(2);
        expect_evt(0);
        btn_level = 4'b0101;
        tick(1);
        check("dis_pre_pending", 32'(pending), 32'b0001);
        enable = 1'b0;
        btn_level = 4'b0111;
        tick(1);
        check("dis_pending_unchanged", 32'(pending), 32'b0001);
        tick(2);
        check("dis_hold_idx", 32'(evt_idx), 32'd2);
        btn_level = 4'b0000;
        tick(1);
        evt_ready = 1'b1;
        tick(6);
        check("dis_pending_drained", 32'(pending), 32'd0);
        check("dis_no_valid", 32'(evt_valid), 32'd0);
        enable = 1'b1;
        tick(2);

        // Reset mid-OFFER discards the event and clears everything at once.
        evt_ready = 1'b0;
        btn_level = 4'b0010;
        tick(2);
        btn_level = 4'b1010;
        tick(1);
        check("rstmid_valid_before", 32'(evt_valid), 32'd1);
        check("rstmid_pending_before", 32'(pending), 32'b1000);
        rst = 1'b1;
        #1;
        check("rstmid_valid_now", 32'(evt_valid), 32'd0);
        btn_level = 4'b0000;
        tick(2);
        rst = 1'b0;
        tick(1);
        check("rstmid_pending_after", 32'(pending), 32'd0);
        check("rstmid_drop_after", 32'(drop_cnt), 32'd0);
        check("rstmid_valid_after", 32'(evt_valid), 32'd0);
        evt_ready = 1'b1;
        tick(5);

`ifdef BTN_REPEAT_EN
        // btn2 held 30 cycles with an 8-cycle repeat period: press plus 3 repeats.
        for (int r = 0; r < 4; r++) begin
            expect_evt(2);
        end
        btn_level = 4'b0100;
        tick(30);
        btn_level = 4'b0000;
        tick(10);
        check("repeat_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        tick(10);
        check("all_events_seen", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Turns the debounced button levels of the memory game into a single stream of button-press events for the game FSM. It sits between the per-button debouncers and the game controller. Each rising edge is latched as a pending request. Pending requests are served round-robin over one valid/ready channel, so simultaneous presses are never lost or reordered unfairly.

## Interface
- `N_BTN`, default 4: number of buttons, 2..16. `IDX_W = $clog2(N_BTN)` is a derived localparam.
- `REPEAT_CYCLES`, default 25_000_000: hold time, in clocks, between auto-repeat events. Used only when `BTN_REPEAT_EN` is defined.
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `btn_level`, in, N_BTN: debounced levels, synchronous to `clk`.
- `enable`, in, 1: when 0, new presses are ignored. Already-pending requests are still delivered.
- `evt_valid`, out, 1: event offered.
- `evt_idx`, out, IDX_W: pressed button index.
- `evt_ready`, in, 1: consumer accepts the event.
- `pending`, out, N_BTN: latched, not-yet-offered requests.
- `drop_cnt`, out, 8: saturating count of presses lost because that button was already pending.

## Operation
- Edge detect: `prev` register, `rise[i] = btn_level[i] & ~prev[i]`.
  - `prev` resets to all-ones, so a button held through reset produces no event.
- Capture: if `enable` and `rise[i]`, set `pending[i]`.
  - If `pending[i]` is already 1 and is not being cleared this cycle, the press is dropped and `drop_cnt` increments, saturating at 255.
  - Simultaneous set and clear on the same bit: set wins, the bit stays 1, and there is no drop.
- FSM states: IDLE and OFFER.
  - IDLE: if `pending != 0`, pick a winner round-robin, searching from `last+1` and wrapping at N_BTN-1→0. Then load `evt_idx`, set `evt_valid`, clear `pending[winner]`, set `last = winner`, and go to OFFER.
  - OFFER: hold `evt_valid` and `evt_idx` stable until `evt_valid & evt_ready`. On the handshake, drop `evt_valid` and return to IDLE.
- Throughput is at most one event per 2 clocks (one bubble in IDLE).
- `evt_ready` while in IDLE has no effect.
- `last` resets to N_BTN-1, so index 0 has first priority after reset.
- Several rises in one cycle: all are latched, then served in round-robin order.
- Reset values: `evt_valid`=0, `evt_idx`=0, `pending`=0, `drop_cnt`=0, state IDLE.
- Reset asserted mid-OFFER: the event is discarded and everything returns to reset values immediately.

## Timing
- Edge k: `btn_level[i]` is first sampled 1. `pending[i]` is 1 after edge k.
- Edge k+1: `evt_valid` is 1 and `pending[i]` is back to 0, assuming IDLE and no competitors. Latency is 2 edges.
- Handshake at edge h: `evt_valid` is 0 after h. The next event can be valid after h+1.
- `evt_valid` and `evt_idx` are registered. Nothing combinational runs from `evt_ready` to any output.
- `drop_cnt` updates one edge after the dropped press is sampled.

## Configuration
- `BTN_REPEAT_EN` defined:
  - Each button gets a hold counter (width `$clog2(REPEAT_CYCLES)`), cleared when `btn_level[i]`=0 or `enable`=0.
  - While held, the counter counts. On reaching REPEAT_CYCLES-1 it generates a synthetic `rise[i]` and restarts at 0.
  - Synthetic rises follow the normal capture and drop rules.
  - Counters reset to 0.
- Not defined: no counters, only true rising edges produce events, and `REPEAT_CYCLES` is ignored.

## Structure
- Package `btn_pkg` holds:
  - the FSM state encoding (IDLE=0, OFFER=1);
  - `DROP_CNT_W` = 8;
  - the reset constant for `prev` (all-ones).
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` [N_BTN], `last` [IDX_W].
  - Outputs: `grant_idx`, `any`.
  - It is reused by the future LED/sound request scheduler.

## Test plan
- Reset with `btn_level`=4'b0010 held → no event; then release and press btn1 → `evt_valid` 2 edges after the press with `evt_idx`=1.
- btn0 and btn2 rise on the same edge with `evt_ready`=1 → events idx 0 then idx 2, back to back with one bubble. Repeat the pair → order 0, 2 again after `last` wraps.
- `evt_ready`=0 for 10 cycles during OFFER → `evt_valid` and `evt_idx` stay stable. Meanwhile press btn3 twice → `pending[3]`=1 and `drop_cnt`=1.
- `enable`=0 and press btn1 → `pending` unchanged and no event; an event already pending before the disable is still delivered.
- Assert `rst` during OFFER → `evt_valid` is 0 immediately, and `pending`=0 and `drop_cnt`=0 after release.
- `BTN_REPEAT_EN` with `REPEAT_CYCLES`=8, btn2 held for 30 cycles → 1 press event plus 3 repeat events, all with idx 2.
